xadc_avg_filter: RTL and testbench

XADC_AVG_FILTER -- requirements
Module: xadc_avg_filter

---
 rtl/xadc_avg_filter.sv | 109 ++++++++++
 tb/tb_xadc_avg_filter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/xadc_avg_filter.sv
// Moving-average filter for XADC DRP samples: averages the last 2^TAPS_LOG2 upper bytes.
// Define XADC_AVG_BYPASS_EN to drop the averager and pass dout_in[15:8] straight through.
module xadc_avg_filter #(
    parameter int unsigned TAPS_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        drdy_in,
    input  logic [15:0] dout_in,
    output logic [7:0]  sample_out,
    output logic        sample_valid,
    output logic        filled
);

    logic [7:0] new_sample;
    logic [7:0] sample_q;
    logic       valid_q;
    logic       unused_bits;

    assign new_sample   = dout_in[15:8];
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;

`ifdef XADC_AVG_BYPASS_EN

    assign unused_bits = ^{dout_in[7:0], TAPS_LOG2[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= drdy_in;
            if (drdy_in) begin
                sample_q <= new_sample;
            end
        end
    end

    assign filled = ~rst;

`else

    localparam int unsigned Depth = 1 << TAPS_LOG2;
    localparam int unsigned SumW  = 8 + TAPS_LOG2;

    typedef enum logic {StFill, StRun} state_e;

    state_e                 state_q, state_d;
    logic [7:0]             ring_q [Depth];
    logic [TAPS_LOG2-1:0]   wptr_q;
    logic [TAPS_LOG2-1:0]   fill_cnt_q;
    logic [SumW-1:0]        sum_q, sum_d;

    assign unused_bits = ^dout_in[7:0];

    // The sum always contains the evicted entry, so the subtraction cannot underflow.
    always_comb begin
        sum_d = sum_q + SumW'(new_sample) - SumW'(ring_q[wptr_q]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                ring_q[i] <= 8'h00;
            end
            wptr_q     <= '0;
            fill_cnt_q <= '0;
            sum_q      <= '0;
            sample_q   <= 8'h00;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= drdy_in;
            if (drdy_in) begin
                ring_q[wptr_q] <= new_sample;
                sum_q          <= sum_d;
                wptr_q         <= wptr_q + TAPS_LOG2'(1);
                sample_q       <= sum_d[SumW-1:TAPS_LOG2];
                if (state_q == StFill) begin
                    fill_cnt_q <= fill_cnt_q + TAPS_LOG2'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill: if (drdy_in && (fill_cnt_q == '1)) state_d = StRun;
            StRun:  state_d = StRun;
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        filled = (state_q == StRun);
    end

`endif

endmodule

// File: tb/tb_xadc_avg_filter.sv
// Directed self-checking bench for xadc_avg_filter (TAPS_LOG2 = 3).
module tb_xadc_avg_filter;

    logic        clk;
    logic        rst;
    logic        drdy_in;
    logic [15:0] dout_in;
    logic [7:0]  sample_out;
    logic        sample_valid;
    logic        filled;

    int total = 0;
    int bad   = 0;

    xadc_avg_filter #(.TAPS_LOG2(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .drdy_in      (drdy_in),
        .dout_in      (dout_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .filled       (filled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din;
        logic [7:0]  exp_out;
        logic        exp_filled;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Returns on the falling edge after the accepting rising edge.
    task automatic accept(input logic [15:0] v);
        @(negedge clk);
        drdy_in = 1'b1;
        dout_in = v;
        @(negedge clk);
        drdy_in = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, "_out"}, {24'h0, sample_out}, 32'h00);
        check({name, "_valid"}, {31'h0, sample_valid}, 32'h0);
        check({name, "_filled"}, {31'h0, filled}, 32'h0);
    endtask

    initial begin
        vec_t       vecs [17];
        int         errs;
        int         pulses;
        logic [7:0] held;

        // Fill ramp, then step to 0xFF through a full wrap, then one 0x00.
        for (int i = 0; i < 8; i++) begin
            vecs[i].din        = 16'h8000;
            vecs[i].exp_out    = 8'((i + 1) * 16);
            vecs[i].exp_filled = (i == 7);
        end
        for (int i = 0; i < 8; i++) begin
            vecs[8 + i].din        = 16'hFF00;
            vecs[8 + i].exp_out    = 8'h8F + 8'(i * 16);
            vecs[8 + i].exp_filled = 1'b1;
        end
        vecs[16].din        = 16'h0000;
        vecs[16].exp_out    = 8'hDF;
        vecs[16].exp_filled = 1'b1;

        rst     = 1'b1;
        drdy_in = 1'b1;
        dout_in = 16'hFF00;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst     = 1'b0;
        drdy_in = 1'b0;
        @(negedge clk);
        @(negedge clk);

`ifdef XADC_AVG_BYPASS_EN
        check("byp_filled_after_release", {31'h0, filled}, 32'h1);
        check("byp_valid_idle", {31'h0, sample_valid}, 32'h0);
        accept(16'h3CAB);
        check("byp_out", {24'h0, sample_out}, 32'h3C);
        check("byp_valid", {31'h0, sample_valid}, 32'h1);
        check("byp_filled", {31'h0, filled}, 32'h1);
        @(negedge clk);
        check("byp_hold_valid", {31'h0, sample_valid}, 32'h0);
        check("byp_hold_out", {24'h0, sample_out}, 32'h3C);
        accept(16'h00FF);
        check("byp_out2", {24'h0, sample_out}, 32'h00);
        check("byp_valid2", {31'h0, sample_valid}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("byp_rst_filled", {31'h0, filled}, 32'h0);
        check("byp_rst_valid", {31'h0, sample_valid}, 32'h0);
        rst = 1'b0;
`else
        check_idle("post_release");

        for (int i = 0; i < 17; i++) begin
            accept(vecs[i].din);
            check($sformatf("vec%0d_valid", i), {31'h0, sample_valid}, 32'h1);
            check($sformatf("vec%0d_out", i), {24'h0, sample_out}, {24'h0, vecs[i].exp_out});
            check($sformatf("vec%0d_filled", i), {31'h0, filled}, {31'h0, vecs[i].exp_filled});
            @(negedge clk);
            check($sformatf("vec%0d_gap_valid", i), {31'h0, sample_valid}, 32'h0);
        end

        repeat (3) @(negedge clk);
        check("hold_out", {24'h0, sample_out}, 32'hDF);
        check("hold_valid", {31'h0, sample_valid}, 32'h0);

        // Back-to-back accepts with no gaps.
        pulses  = 0;
        drdy_in = 1'b1;
        dout_in = 16'h4000;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) pulses++;
            if (i == 15) drdy_in = 1'b0;
        end
        check("b2b_pulses", pulses, 32'd16);
        check("b2b_out", {24'h0, sample_out}, 32'h40);
        @(negedge clk);
        check("b2b_after_valid", {31'h0, sample_valid}, 32'h0);

        // Sparse pulses: window is all 0x40, each 0x80 adds 8 to the mean.
        for (int p = 0; p < 3; p++) begin
            accept(16'h8000);
            check($sformatf("sparse%0d_valid", p), {31'h0, sample_valid}, 32'h1);
            check($sformatf("sparse%0d_out", p), {24'h0, sample_out}, 32'h48 + 32'(p * 8));
            held = sample_out;
            errs = 0;
            for (int c = 0; c < 48; c++) begin
                @(negedge clk);
                if (sample_valid !== 1'b0 || sample_out !== held) errs++;
            end
            check($sformatf("sparse%0d_quiet", p), errs, 32'd0);
        end

        // Mid-stream reset with drdy held high discards all history.
        accept(16'h1234);
        rst     = 1'b1;
        drdy_in = 1'b1;
        dout_in = 16'hFF00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_idle($sformatf("midrst%0d", c));
        end
        rst     = 1'b0;
        drdy_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_idle($sformatf("after_rst%0d", c));
        end
        accept(16'h8000);
        check("restart_out", {24'h0, sample_out}, 32'h10);
        check("restart_valid", {31'h0, sample_valid}, 32'h1);
        check("restart_filled", {31'h0, filled}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
